fft_bar_binner: RTL and testbench

- Sits directly downstream of the 1024-point FFT wrapper and consumes its complex output stream (source_valid, source_eop, source_real, source_imag).
- Computes an approximate magnitude for each bin and peak-holds bins 0..N/2-1 into NUM_BARS bar values of mag_width bits.
- Bar values are kept in a double-buffered bank, so the VGA renderer reads a stable completed frame while the next frame accumulates.

---
 rtl/fft_bar_binner.sv | 129 ++++++++++++
 tb/tb_fft_bar_binner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bar_binner.sv
// Magnitude binner for the 1024-point FFT output stream: approximates |X[k]| per bin,
// peak-holds the lower half into NUM_BARS bars and double-buffers them for the renderer.
module fft_bar_binner #(
  parameter int unsigned N           = 1024,
  parameter int unsigned fp_width    = 32,
  parameter int unsigned mag_width   = 9,
  parameter int unsigned NUM_BARS    = 64,
  parameter int unsigned SCALE_SHIFT = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        source_valid,
  input  logic                        source_eop,
  input  logic [fp_width-1:0]         source_real,
  input  logic [fp_width-1:0]         source_imag,
  input  logic [$clog2(NUM_BARS)-1:0] bar_sel,
  output logic [mag_width-1:0]        bar_mag,
  output logic                        frame_done,
  output logic                        frame_err
);

  localparam int unsigned KW        = $clog2(N) + 1;
  localparam int unsigned BW        = $clog2(NUM_BARS);
  localparam int unsigned BIN_SHIFT = $clog2((N / 2) / NUM_BARS);
  localparam int unsigned AW        = fp_width - 1;
  localparam int unsigned RW        = fp_width + 1;

  // |x| of a two's complement value, with the most negative input clamped to max positive
  function automatic logic [AW-1:0] abs_sat(input logic [fp_width-1:0] x);
    logic [fp_width-1:0] neg;
    neg = fp_width'(0) - x;
    if (!x[fp_width-1])      return x[AW-1:0];
    else if (neg[fp_width-1]) return {AW{1'b1}};
    else                      return neg[AW-1:0];
  endfunction

  logic [KW-1:0]        k;
  logic                 s1_valid, s1_eop, s2_valid, s2_eop, s3_valid, s3_eop;
  logic [KW-1:0]        s1_k, s2_k, s3_k;
  logic [AW-1:0]        s1_re, s1_im, s2_mx, s2_mn;
  logic [mag_width-1:0] s3_mag;
  logic [RW-1:0]        raw_c, shifted_c;
  logic [mag_width-1:0] mag_c;
  logic                 accept_c;

  assign accept_c = source_valid && (k != KW'(N));

  always_comb begin
    raw_c     = RW'(s2_mx) + RW'(s2_mn >> 2) + RW'(s2_mn >> 3);
    shifted_c = raw_c >> SCALE_SHIFT;
    mag_c     = (|shifted_c[RW-1:mag_width]) ? {mag_width{1'b1}} : shifted_c[mag_width-1:0];
  end

  // Bin counter, error flag and the three magnitude stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k         <= '0;
      frame_err <= 1'b0;
      s1_valid  <= 1'b0;
      s1_eop    <= 1'b0;
      s1_k      <= '0;
      s1_re     <= '0;
      s1_im     <= '0;
      s2_valid  <= 1'b0;
      s2_eop    <= 1'b0;
      s2_k      <= '0;
      s2_mx     <= '0;
      s2_mn     <= '0;
      s3_valid  <= 1'b0;
      s3_eop    <= 1'b0;
      s3_k      <= '0;
      s3_mag    <= '0;
    end else begin
      if (source_valid) begin
        if (k == KW'(N)) begin
          frame_err <= 1'b1;
          if (source_eop) k <= '0;
        end else if (source_eop) begin
          k <= '0;
          if (k != KW'(N - 1)) frame_err <= 1'b1;
        end else begin
          k <= k + KW'(1);
        end
      end
      s1_valid <= accept_c;
      s1_eop   <= source_eop;
      s1_k     <= k;
      s1_re    <= abs_sat(source_real);
      s1_im    <= abs_sat(source_imag);
      s2_valid <= s1_valid;
      s2_eop   <= s1_eop;
      s2_k     <= s1_k;
      s2_mx    <= (s1_re > s1_im) ? s1_re : s1_im;
      s2_mn    <= (s1_re > s1_im) ? s1_im : s1_re;
      s3_valid <= s2_valid;
      s3_eop   <= s2_eop;
      s3_k     <= s2_k;
      s3_mag   <= mag_c;
    end
  end

  logic [mag_width-1:0] bank [2][NUM_BARS];
  logic                 sel;
  logic [BW-1:0]        bar_idx_c;
  logic                 acc_en_c;

  assign bar_idx_c = BW'(s3_k >> BIN_SHIFT);
  assign acc_en_c  = s3_valid && (s3_k < KW'(N / 2)) && (s3_mag > bank[sel][bar_idx_c]);

  // sel names the working bank; the eop sample lands in it on the same edge it is retired
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++)
        for (int j = 0; j < int'(NUM_BARS); j++) bank[b][j] <= '0;
      sel        <= 1'b0;
      bar_mag    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= s3_valid && s3_eop;
      bar_mag    <= bank[~sel][bar_sel];
      if (acc_en_c) bank[sel][bar_idx_c] <= s3_mag;
      if (s3_valid && s3_eop) begin
        sel <= ~sel;
        for (int j = 0; j < int'(NUM_BARS); j++) bank[~sel][j] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bar_binner.sv
// Directed bench for fft_bar_binner: two instances (SCALE_SHIFT 12 and 0) share one stimulus
// stream and are compared every cycle against a frame-level model of the committed bars.
module tb_fft_bar_binner;

  localparam int NB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        source_valid = 1'b0;
  logic        source_eop = 1'b0;
  logic [31:0] source_real = '0;
  logic [31:0] source_imag = '0;
  logic [5:0]  bar_sel = '0;
  logic [8:0]  bar_mag_a, bar_mag_b;
  logic        frame_done_a, frame_done_b, frame_err_a, frame_err_b;

  fft_bar_binner #(.SCALE_SHIFT(12)) dut_a (
    .clk(clk), .reset_n(reset_n), .source_valid(source_valid), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .bar_sel(bar_sel),
    .bar_mag(bar_mag_a), .frame_done(frame_done_a), .frame_err(frame_err_a));

  fft_bar_binner #(.SCALE_SHIFT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .source_valid(source_valid), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .bar_sel(bar_sel),
    .bar_mag(bar_mag_b), .frame_done(frame_done_b), .frame_err(frame_err_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [5:0] sel_q = '0;
  bit chk_en = 1'b0;

  // Model: bars being built from driven samples, committed snapshot awaiting display, displayed bars
  int work [2][NB];
  int pend [2][NB];
  int disp [2][NB];
  int pend_due = -1;
  int err_at = -1;
  int k_m = 0;
  int shamt [2] = '{12, 0};
  logic [31:0] fre [1024];
  logic [31:0] fim [1024];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint abs_l(input logic [31:0] v);
    longint x;
    x = longint'($signed(v));
    if (x < 0) x = -x;
    if (x > 64'sd2147483647) x = 64'sd2147483647;
    return x;
  endfunction

  function automatic int mag_of(input logic [31:0] re, input logic [31:0] im, input int sh);
    longint a, b, mx, mn, raw;
    a = abs_l(re);
    b = abs_l(im);
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    raw = (mx + (mn >> 2) + (mn >> 3)) >> sh;
    if (raw > 511) raw = 511;
    return int'(raw);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < NB; j++) begin
        work[i][j] = 0;
        pend[i][j] = 0;
        disp[i][j] = 0;
      end
    pend_due = -1;
    err_at = -1;
    k_m = 0;
  endtask

  task automatic clear_spec();
    for (int i = 0; i < 1024; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    sel_q <= bar_sel;
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_done;
      bit exp_err;
      exp_done = (pend_due == cyc);
      exp_err = (err_at >= 0) && (cyc >= err_at);
      check("bar_mag_a", int'(bar_mag_a), disp[0][sel_q]);
      check("bar_mag_b", int'(bar_mag_b), disp[1][sel_q]);
      check("frame_done_a", int'(frame_done_a), int'(exp_done));
      check("frame_done_b", int'(frame_done_b), int'(exp_done));
      check("frame_err_a", int'(frame_err_a), int'(exp_err));
      check("frame_err_b", int'(frame_err_b), int'(exp_err));
      if (exp_done) begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < NB; j++) disp[i][j] = pend[i][j];
        pend_due = -1;
      end
    end
  end

  task automatic drive_sample(input logic [31:0] re, input logic [31:0] im, input bit eop);
    @(posedge clk);
    #1;
    source_valid = 1'b1;
    source_eop = eop;
    source_real = re;
    source_imag = im;
    bar_sel = bar_sel + 6'd1;
    if (k_m == 1024) begin
      if (err_at < 0) err_at = cyc + 1;
      if (eop) k_m = 0;
    end else begin
      if (k_m < 512)
        for (int i = 0; i < 2; i++) begin
          int m;
          m = mag_of(re, im, shamt[i]);
          if (m > work[i][k_m / 8]) work[i][k_m / 8] = m;
        end
      if (eop) begin
        if (k_m != 1023 && err_at < 0) err_at = cyc + 1;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < NB; j++) begin
            pend[i][j] = work[i][j];
            work[i][j] = 0;
          end
        pend_due = cyc + 4;
        k_m = 0;
      end else begin
        k_m++;
      end
    end
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    source_valid = 1'b0;
    source_eop = 1'b0;
    bar_sel = bar_sel + 6'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_idle();
  endtask

  task automatic read_bar(input int s, input int exp_a, input int exp_b);
    @(posedge clk);
    #1;
    source_valid = 1'b0;
    source_eop = 1'b0;
    bar_sel = 6'(s);
    @(posedge clk);
    #1;
    check($sformatf("lit_bar%0d_a", s), int'(bar_mag_a), exp_a);
    check($sformatf("lit_bar%0d_b", s), int'(bar_mag_b), exp_b);
  endtask

  task automatic send_range(input int lo, input int hi, input bit bub, input bit eop_last);
    for (int i = lo; i <= hi; i++) begin
      drive_sample(fre[i], fim[i], eop_last && (i == hi));
      if (bub) drive_idle();
    end
  endtask

  initial begin
    model_reset();
    clear_spec();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    for (int s = 0; s < NB; s++) read_bar(s, 0, 0);
    check("lit_reset_err", int'(frame_err_a), 0);
    check("lit_reset_done", int'(frame_done_a), 0);

    // Single tone at bin 17; frame_done appears on the fourth cycle after the eop cycle
    clear_spec();
    fre[17] = 32'h0010_0000;
    send_range(0, 1023, 1'b0, 1'b1);
    idle(3);
    check("lit_done_early", int'(frame_done_a), 0);
    idle(1);
    check("lit_done_pulse", int'(frame_done_a), 1);
    idle(1);
    check("lit_done_after", int'(frame_done_a), 0);
    read_bar(2, 256, 511);
    read_bar(3, 0, 0);
    read_bar(0, 0, 0);
    check("lit_tone_err", int'(frame_err_a), 0);

    // Peak hold within a bar and saturation of the most negative input
    clear_spec();
    fre[0] = 32'hFFFF_FF38;
    fim[0] = 32'd80;
    fre[1] = 32'd300;
    fre[8] = 32'h8000_0000;
    send_range(0, 1023, 1'b0, 1'b1);
    idle(6);
    read_bar(0, 0, 300);
    read_bar(1, 511, 511);
    read_bar(2, 0, 0);

    // Mirror-half bin is ignored
    clear_spec();
    fre[600] = 32'h7FFF_FFFF;
    fim[600] = 32'h7FFF_FFFF;
    send_range(0, 1023, 1'b0, 1'b1);
    idle(6);
    for (int s = 0; s < NB; s++) read_bar(s, 0, 0);

    // Display bank holds frame 1 while a bubbled frame 2 accumulates
    clear_spec();
    fre[17] = 32'h0010_0000;
    send_range(0, 1023, 1'b0, 1'b1);
    idle(6);
    clear_spec();
    fre[17] = 32'h0008_0000;
    fim[100] = 32'hFFE0_0000;
    send_range(0, 299, 1'b1, 1'b0);
    read_bar(2, 256, 511);
    send_range(300, 1023, 1'b1, 1'b1);
    idle(6);
    read_bar(2, 128, 511);
    read_bar(12, 511, 511);

    // Short frame commits with the error flag; reset mid-frame clears everything
    clear_spec();
    fre[50] = 32'h0030_0000;
    send_range(0, 99, 1'b0, 1'b1);
    idle(6);
    read_bar(6, 511, 511);
    check("lit_short_err_a", int'(frame_err_a), 1);
    check("lit_short_err_b", int'(frame_err_b), 1);
    clear_spec();
    fre[20] = 32'h0010_0000;
    send_range(0, 199, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    source_valid = 1'b0;
    source_eop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    read_bar(6, 0, 0);
    read_bar(2, 0, 0);
    check("lit_post_reset_err", int'(frame_err_a), 0);
    clear_spec();
    fre[17] = 32'h0010_0000;
    send_range(0, 1023, 1'b0, 1'b1);
    idle(6);
    read_bar(2, 256, 511);
    check("lit_restart_err", int'(frame_err_a), 0);

    idle(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
